// File: rtl/param_loader.sv
// Serialises parameter bytes MSB-first onto a neuron setup chain, one bit per
// setup cycle; stalls the chain (setup=0) whenever no buffered bit is available.
module param_loader #(
   parameter int CHAIN_BITS = 11
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] data_in,
   input  logic       data_valid,
   output logic       data_ready,
   output logic       setup,
   output logic       param_out,
   output logic       busy,
   output logic       done
);

   localparam int NBYTES = (CHAIN_BITS + 7) / 8;
   localparam int BW     = $clog2(CHAIN_BITS + 1);
   localparam int YW     = $clog2(NBYTES + 1);
   localparam logic [BW-1:0] LAST_BIT  = BW'(CHAIN_BITS);
   localparam logic [YW-1:0] LAST_BYTE = YW'(NBYTES);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOAD = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]    state;
   logic [BW-1:0] bit_cnt;
   logic [YW-1:0] byte_cnt;
   logic [6:0]    sh;
   logic [2:0]    sh_cnt;
   logic [7:0]    hold;
   logic          hold_full;

   logic in_load, accept, avail, take, next_bit;

   // The output register is the first serial stage, so the shifter only ever
   // holds the 7 bits left after a byte's MSB has been issued.
   always_comb begin
      in_load    = (state == S_LOAD);
      data_ready = in_load & ~hold_full & (byte_cnt != LAST_BYTE);
      accept     = data_valid & data_ready;
      avail      = (sh_cnt != 3'd0) | hold_full | accept;
      take       = in_load & avail & (bit_cnt != LAST_BIT);
      if (sh_cnt != 3'd0)
         next_bit = sh[6];
      else if (hold_full)
         next_bit = hold[7];
      else
         next_bit = data_in[7];
   end

   assign busy = (state == S_LOAD);
   assign done = (state == S_DONE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         bit_cnt   <= '0;
         byte_cnt  <= '0;
         sh        <= '0;
         sh_cnt    <= '0;
         hold      <= '0;
         hold_full <= 1'b0;
         setup     <= 1'b0;
         param_out <= 1'b0;
      end else begin
         setup     <= take;
         param_out <= take & next_bit;

         case (state)
            S_IDLE: if (start) begin
               state     <= S_LOAD;
               bit_cnt   <= '0;
               byte_cnt  <= '0;
               sh_cnt    <= '0;
               hold_full <= 1'b0;
            end
            S_LOAD: if (bit_cnt == LAST_BIT) state <= S_DONE;
            S_DONE: state <= S_IDLE;
            default: state <= S_IDLE;
         endcase

         if (accept) byte_cnt <= byte_cnt + YW'(1);

         // Drain order: shifter, then holding byte, then the byte arriving now.
         if (take) begin
            bit_cnt <= bit_cnt + BW'(1);
            if (sh_cnt != 3'd0) begin
               sh     <= {sh[5:0], 1'b0};
               sh_cnt <= sh_cnt - 3'd1;
               if (accept) begin
                  hold      <= data_in;
                  hold_full <= 1'b1;
               end
            end else if (hold_full) begin
               sh        <= hold[6:0];
               sh_cnt    <= 3'd7;
               hold_full <= 1'b0;
            end else begin
               sh     <= data_in[6:0];
               sh_cnt <= 3'd7;
            end
         end else if (accept) begin
            hold      <= data_in;
            hold_full <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_param_loader.sv
// Directed bench for param_loader: three instances (CHAIN_BITS 11, 24, 1)
// with per-instance monitors recording setup bits, handshakes and done timing.
module tb_param_loader;

   typedef struct {
      int          nset, nhs, ndone, nbad;
      int          first_hs, first_set, last_set, done_at;
      logic [31:0] bits;
   } mon_t;

   logic             clk;
   logic [2:0]       rst, start, data_valid, data_ready, setup, param_out, busy, done, mclr;
   logic [2:0][7:0]  data_in;
   int               cyc = 0;
   int               nvec = 0;
   int               nerr = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int CB = (g == 0) ? 11 : (g == 1) ? 24 : 1;
      mon_t m;
      param_loader #(.CHAIN_BITS(CB)) u_dut (
         .clk(clk), .reset(rst[g]), .start(start[g]), .data_in(data_in[g]),
         .data_valid(data_valid[g]), .data_ready(data_ready[g]), .setup(setup[g]),
         .param_out(param_out[g]), .busy(busy[g]), .done(done[g]));

      always @(negedge clk) begin
         if (mclr[g]) begin
            m.nset = 0; m.nhs = 0; m.ndone = 0; m.nbad = 0;
            m.first_hs = -1; m.first_set = -1; m.last_set = -1; m.done_at = -1;
            m.bits = '0;
         end else begin
            if (setup[g]) begin
               if (m.nset == 0) m.first_set = cyc;
               m.nset++;
               m.last_set = cyc;
               m.bits = {m.bits[30:0], param_out[g]};
               if (!busy[g]) m.nbad++;
            end
            if (data_valid[g] && data_ready[g]) begin
               if (m.nhs == 0) m.first_hs = cyc;
               m.nhs++;
            end
            if (done[g]) begin
               m.ndone++;
               m.done_at = cyc;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_run(input string tag, input mon_t m, input logic [31:0] exp_bits,
                          input int n, input int hs, input int span);
      logic [31:0] mask;
      mask = (n >= 32) ? 32'hFFFF_FFFF : ((32'h1 << n) - 32'h1);
      chk({tag, ":nset"}, m.nset, n);
      chk({tag, ":bits"}, m.bits & mask, exp_bits);
      chk({tag, ":handshakes"}, m.nhs, hs);
      chk({tag, ":ndone"}, m.ndone, 1);
      chk({tag, ":done_timing"}, m.done_at, m.last_set + 1);
      chk({tag, ":span"}, m.last_set - m.first_set + 1, span);
      chk({tag, ":latency"}, m.first_set, m.first_hs + 1);
      chk({tag, ":setup_outside_load"}, m.nbad, 0);
   endtask

   // Starts a load on instance i and feeds nb bytes; gap idles data_valid
   // between bytes, poke pulses start again after the first byte.
   task automatic load(input int i, input logic [7:0] b0, input logic [7:0] b1,
                       input logic [7:0] b2, input int nb, input int gap, input bit poke);
      logic [7:0] bs[3];
      int w;
      bs[0] = b0; bs[1] = b1; bs[2] = b2;
      mclr[i] = 1'b1; tick(); mclr[i] = 1'b0;
      start[i] = 1'b1; tick(); start[i] = 1'b0;
      chk("busy_in_load", busy[i], 1);
      for (int k = 0; k < nb; k++) begin
         data_in[i] = bs[k];
         data_valid[i] = 1'b1;
         w = 0;
         while (!data_ready[i] && w < 30) begin tick(); w++; end
         chk("ready_wait", (w < 30), 1);
         tick();
         if (poke && k == 0) begin
            data_valid[i] = 1'b0;
            start[i] = 1'b1; tick(); start[i] = 1'b0;
            chk("busy_after_poke", busy[i], 1);
         end
         if (k < nb - 1 && gap > 0) begin
            data_valid[i] = 1'b0;
            repeat (gap) tick();
         end
      end
      chk("ready_after_last", data_ready[i], 0);
      data_in[i] = 8'hFF;
      data_valid[i] = 1'b1;
      w = 0;
      while (!done[i] && w < 60) begin tick(); w++; end
      chk("done_seen", done[i], 1);
      data_valid[i] = 1'b0;
      tick(); tick();
      chk("idle_after", {busy[i], done[i], setup[i]}, 0);
   endtask

   initial begin
      int n, w;
      rst = '1; start = '0; data_valid = '0; mclr = '0; data_in = '0;
      repeat (3) tick();
      chk("reset_outputs", {setup[0], param_out[0], data_ready[0], busy[0], done[0]}, 0);
      chk("reset_outputs_24", {setup[1], param_out[1], data_ready[1], busy[1], done[1]}, 0);
      start[0] = 1'b1; tick();
      chk("reset_overrides_start", busy[0], 0);
      rst = '0; start[0] = 1'b0; tick();
      chk("idle_ready_low", {busy[0], data_ready[0]}, 0);

      // 0xA5,0xE0 onto an 8-weight/3-bit-bias neuron: bias=5, weights=0x2F
      load(0, 8'hA5, 8'hE0, 8'h00, 2, 0, 1'b0);
      chk_run("cb11", g_dut[0].m, 32'h52F, 11, 2, 11);
      chk("neuron_weights", g_dut[0].m.bits[7:0], 8'h2F);
      chk("neuron_bias", g_dut[0].m.bits[10:8], 3'd5);

      load(1, 8'h3C, 8'h81, 8'hF6, 3, 0, 1'b0);
      chk_run("cb24", g_dut[1].m, 32'h3C81F6, 24, 3, 24);

      // a 10-cycle gap starves the chain for 3 cycles
      load(0, 8'hA5, 8'hE0, 8'h00, 2, 10, 1'b0);
      chk_run("cb11_gap", g_dut[0].m, 32'h52F, 11, 2, 14);

      load(0, 8'hA5, 8'hE0, 8'h00, 2, 0, 1'b1);
      chk_run("cb11_start_poke", g_dut[0].m, 32'h52F, 11, 2, 11);

      // abort after the 6th setup cycle
      mclr[0] = 1'b1; tick(); mclr[0] = 1'b0;
      start[0] = 1'b1; tick(); start[0] = 1'b0;
      data_in[0] = 8'hA5; data_valid[0] = 1'b1;
      n = 0; w = 0;
      while (n < 6 && w < 40) begin
         tick(); w++;
         if (setup[0]) n++;
      end
      chk("abort_reached_6", n, 6);
      rst[0] = 1'b1; data_valid[0] = 1'b0; tick();
      chk("abort_outputs", {setup[0], param_out[0], data_ready[0], busy[0], done[0]}, 0);
      rst[0] = 1'b0;
      repeat (15) tick();
      chk("abort_nset", g_dut[0].m.nset, 6);
      chk("abort_no_done", g_dut[0].m.ndone, 0);
      load(0, 8'hA5, 8'hE0, 8'h00, 2, 0, 1'b0);
      chk_run("cb11_reload", g_dut[0].m, 32'h52F, 11, 2, 11);

      load(2, 8'h80, 8'h00, 8'h00, 1, 0, 1'b0);
      chk_run("cb1", g_dut[2].m, 32'h1, 1, 1, 1);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
